// File: rtl/fft_frame_packer_pkg.sv
// Shared constants and types for the FFT frame packer.
package fft_frame_pkg;

  localparam int DW        = 16;
  localparam int IW        = 12;
  localparam int LOG2N     = 8;
  localparam int FRAME_LEN = 2 ** LOG2N;
  localparam int TW        = IW - LOG2N;   // frame tag width
  localparam int AW        = LOG2N + 1;    // {bank, idx}

  localparam logic [7:0] SAT_MAX = 8'd255;

  typedef enum logic [1:0] {
    HUNT,
    CAPTURE,
    DROP
  } wr_state_t;

endpackage

// File: rtl/fft_frame_packer_if.sv
// Framed sample stream from the packer to the FFT core (valid/ready, sop/eop, tag).
interface fft_frame_packer_if;
  import fft_frame_pkg::*;

  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sop;
  logic          out_eop;
  logic [TW-1:0] out_tag;

  modport master (
    output out_data, out_valid, out_sop, out_eop, out_tag,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_sop, out_eop, out_tag,
    output out_ready
  );

endinterface

// File: rtl/fft_frame_packer_bank_ram.sv
// Two-bank ping-pong sample RAM: one write port, one registered read port.
module fft_frame_bank_ram
  import fft_frame_pkg::*;
(
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2*FRAME_LEN];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_frame_packer.sv
// Cuts the indexed sample stream into aligned frames, double-buffers them and
// streams each frame to the FFT core with sop/eop/tag framing.
module fft_frame_packer
  import fft_frame_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] din,
  input  logic [IW-1:0]        din_idx,
  input  logic                 din_valid,
  fft_frame_packer_if.master   out_if,
  output logic                 overflow,
  output logic [7:0]           sync_err_cnt
);

  wr_state_t     r_state;
  logic [IW-1:0] r_exp;
  logic          r_wr_bank;
  logic [TW-1:0] r_bank_tag [2];
  logic          r_overflow;
  logic [7:0]    r_sync_err;

  logic [1:0]       r_cnt;
  logic [1:0]       r_fq;
  logic             r_fetch_bank;
  logic [LOG2N-1:0] r_fetch_idx;

  logic          r_pf_valid;
  logic          r_pf_sop;
  logic          r_pf_eop;
  logic [TW-1:0] r_pf_tag;

  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic          r_out_sop;
  logic          r_out_eop;
  logic [TW-1:0] r_out_tag;

  logic [LOG2N-1:0] w_low;
  logic             w_frame_first;
  logic             w_frame_last;
  logic             w_bank_free;
  logic             w_mismatch;
  logic             w_hunt_eval;
  logic             w_start;
  logic             w_ovf;
  logic             w_cap;
  logic             w_abort;
  logic             w_commit;
  logic             w_we;
  logic             w_out_free;
  logic             w_issue;
  logic             w_move;
  logic             w_fetch_last;
  logic             w_release;
  logic [DW-1:0]    w_ram_rdata;

  assign w_low         = din_idx[LOG2N-1:0];
  assign w_frame_first = (w_low == '0);
  assign w_frame_last  = (w_low == '1);
  assign w_bank_free   = (r_cnt < 2'd2);
  assign w_mismatch    = (din_idx != r_exp);

  // An out-of-sequence sample in CAPTURE aborts the frame and is then judged
  // as if in HUNT, so an idx-0 sample can open the next frame in the same cycle.
  assign w_hunt_eval = din_valid && ((r_state == HUNT) || ((r_state == CAPTURE) && w_mismatch));
  assign w_start     = w_hunt_eval && w_frame_first && w_bank_free;
  assign w_ovf       = w_hunt_eval && w_frame_first && !w_bank_free;
  assign w_cap       = din_valid && (r_state == CAPTURE) && !w_mismatch;
  assign w_abort     = din_valid && (r_state == CAPTURE) && w_mismatch;
  assign w_commit    = w_cap && w_frame_last;
  assign w_we        = w_start || w_cap;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= HUNT;
      r_exp      <= '0;
      r_wr_bank  <= 1'b0;
      r_overflow <= 1'b0;
      r_sync_err <= '0;
      for (int unsigned i = 0; i < 2; i++) r_bank_tag[i] <= '0;
    end else begin
      if (w_start) begin
        r_state               <= CAPTURE;
        r_exp                 <= din_idx + IW'(1);
        r_bank_tag[r_wr_bank] <= din_idx[IW-1:LOG2N];
      end else if (w_ovf) begin
        r_state    <= DROP;
        r_overflow <= 1'b1;
      end else if (w_cap) begin
        r_exp <= din_idx + IW'(1);
        if (w_frame_last) r_state <= HUNT;
      end else if (w_abort) begin
        r_state <= HUNT;
      end else if (din_valid && (r_state == DROP) && w_frame_last) begin
        r_state <= HUNT;
      end

      if (w_abort && (r_sync_err != SAT_MAX)) r_sync_err <= r_sync_err + 8'd1;
      if (w_commit) r_wr_bank <= ~r_wr_bank;
    end
  end

  // r_cnt: banks holding a committed frame until its eop transfers.
  // r_fq:  committed banks not yet fully fetched; fetching runs ahead of release.
  assign w_out_free   = !r_out_valid || out_if.out_ready;
  assign w_issue      = (r_fq != 2'd0) && (!r_pf_valid || w_out_free);
  assign w_move       = r_pf_valid && w_out_free;
  assign w_fetch_last = (r_fetch_idx == '1);
  assign w_release    = r_out_valid && out_if.out_ready && r_out_eop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= '0;
      r_fq         <= '0;
      r_fetch_bank <= 1'b0;
      r_fetch_idx  <= '0;
    end else begin
      case ({w_commit, w_release})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase

      case ({w_commit, w_issue && w_fetch_last})
        2'b10:   r_fq <= r_fq + 2'd1;
        2'b01:   r_fq <= r_fq - 2'd1;
        default: r_fq <= r_fq;
      endcase

      if (w_issue) begin
        r_fetch_idx <= r_fetch_idx + LOG2N'(1);
        if (w_fetch_last) r_fetch_bank <= ~r_fetch_bank;
      end
    end
  end

  fft_frame_bank_ram u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr ({r_wr_bank, w_low}),
    .i_wdata (din),
    .i_re    (w_issue),
    .i_raddr ({r_fetch_bank, r_fetch_idx}),
    .o_rdata (w_ram_rdata)
  );

  // The RAM output register is the prefetch slot; it is only reloaded when
  // its current word is moving into the output stage or is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pf_valid  <= 1'b0;
      r_pf_sop    <= 1'b0;
      r_pf_eop    <= 1'b0;
      r_pf_tag    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_tag   <= '0;
    end else begin
      if (w_issue) begin
        r_pf_valid <= 1'b1;
        r_pf_sop   <= (r_fetch_idx == '0);
        r_pf_eop   <= w_fetch_last;
        r_pf_tag   <= r_bank_tag[r_fetch_bank];
      end else if (w_move) begin
        r_pf_valid <= 1'b0;
      end

      if (w_move) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ram_rdata;
        r_out_sop   <= r_pf_sop;
        r_out_eop   <= r_pf_eop;
        r_out_tag   <= r_pf_tag;
      end else if (out_if.out_ready) begin
        r_out_valid <= 1'b0;
        r_out_sop   <= 1'b0;
        r_out_eop   <= 1'b0;
      end
    end
  end

  assign out_if.out_valid = r_out_valid;
  assign out_if.out_data  = r_out_data;
  assign out_if.out_sop   = r_out_sop;
  assign out_if.out_eop   = r_out_eop;
  assign out_if.out_tag   = r_out_tag;
  assign overflow         = r_overflow;
  assign sync_err_cnt     = r_sync_err;

endmodule
